// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared definitions for the fetch sequencer and its users.
//   - state encoding (3-bit) and the state_t enum built on it
//   - frame field bit positions and the decoded-field struct
//   - terminator frame constant and a helper to detect it
// Optional build macro used by fetch_seq: FETCH_LOOP_EN.
package fetch_seq_pkg;

  localparam int FRAME_W = 17;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_VALID = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_VALID = ST_VALID,
    S_HALT  = ST_HALT
  } state_t;

  localparam int OP_MSB  = 16;
  localparam int OP_LSB  = 13;
  localparam int DST_MSB = 12;
  localparam int DST_LSB = 9;
  localparam int IMM_BIT = 8;
  localparam int VAL_MSB = 7;

  localparam logic [FRAME_W-1:0] TERMINATOR = 17'b0;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] dst;
    logic       imm;
    logic [7:0] val;
  } fields_t;

  function automatic logic is_terminator(input logic [FRAME_W-1:0] frame);
    return (frame == TERMINATOR);
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: ROM bus plus decoded-frame output bus of the fetch sequencer.
// Ports (signals):
//   mem_addr  ROM address          mem_en   ROM read enable
//   mem_data  ROM registered frame out_valid/out_ready  output handshake
//   out_op/out_dst/out_imm/out_val decoded frame fields
// Modports: master = fetch_seq side, slave = ROM + execute-stage side.
//
// Handshake: a frame transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, with all out_*
// fields stable, until that transfer; out_ready is ignored while out_valid
// is low.
interface fetch_seq_if #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 17
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [WIDTH-1:0]  mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [3:0]        out_dst;
  logic              out_imm;
  logic [7:0]        out_val;

  modport master (
    output mem_addr, mem_en, out_valid, out_op, out_dst, out_imm, out_val,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_en, out_valid, out_op, out_dst, out_imm, out_val,
    output mem_data, out_ready
  );
endinterface

// File: rtl/fetch_seq_frame_split.sv
// fetch_seq_frame_split: purely combinational frame field extractor.
// Ports:
//   i_frame   17-bit instruction frame
//   o_fields  op/dst/imm/val fields of that frame
module fetch_seq_frame_split
  import fetch_seq_pkg::*;
(
  input  logic [FRAME_W-1:0] i_frame,
  output fields_t            o_fields
);
  always_comb begin
    o_fields.op  = i_frame[OP_MSB:OP_LSB];
    o_fields.dst = i_frame[DST_MSB:DST_LSB];
    o_fields.imm = i_frame[IMM_BIT];
    o_fields.val = i_frame[VAL_MSB:0];
  end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: walks the instruction ROM, captures each registered frame,
// splits it into fields and offers it downstream on a valid/ready bus.
// Stops on the all-zero terminator frame.
// Ports:
//   clk, rst_n  clock (rising edge) and async active-low reset
//   start       begin fetching at address 0 (honoured in IDLE/HALT only)
//   bus         fetch_seq_if.master: ROM bus + decoded output handshake
//   busy        high in FETCH, WAIT or VALID
//   halted      high in HALT
//   issue_cnt   frames accepted since last start, saturating
//   dbg_state   current FSM state
// Build option: FETCH_LOOP_EN -- a terminator restarts at address 0 instead
// of halting, keeping issue_cnt.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 17,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  fetch_seq_if.master      bus,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] issue_cnt,
  output state_t           dbg_state
);

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  fields_t           r_fields;
  fields_t           w_fields;
  logic              w_load;
  logic              w_zero;

  fetch_seq_frame_split u_split (
    .i_frame  (bus.mem_data[FRAME_W-1:0]),
    .o_fields (w_fields)
  );

  assign w_zero = is_terminator(bus.mem_data[FRAME_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_fields <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_fields <= w_fields;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT;
      // ROM output for the address presented in FETCH is valid here.
      S_WAIT: begin
        if (w_zero) begin
`ifdef FETCH_LOOP_EN
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
`else
          w_state_nxt = S_HALT;
`endif
        end else begin
          w_state_nxt = S_VALID;
          w_load      = 1'b1;
        end
      end
      S_VALID: begin
        if (bus.out_ready) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = r_pc + PC_ONE;   // wraps modulo 2^ADDR_W
          w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // mem_addr mirrors pc at all times, so it is registered by construction.
  assign bus.mem_addr  = r_pc;
  assign bus.mem_en    = (r_state == S_FETCH);
  assign bus.out_valid = (r_state == S_VALID);
  assign bus.out_op    = r_fields.op;
  assign bus.out_dst   = r_fields.dst;
  assign bus.out_imm   = r_fields.imm;
  assign bus.out_val   = r_fields.val;

  assign busy      = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                     (r_state == S_VALID);
  assign halted    = (r_state == S_HALT);
  assign issue_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq with a registered ROM model.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, halted;
  logic [7:0] issue_cnt;
  state_t     dbg_state;

  fetch_seq_if #(.ADDR_W(3), .WIDTH(17)) bus ();

  fetch_seq #(.ADDR_W(3), .WIDTH(17), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .issue_cnt (issue_cnt),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // registered ROM model
  logic [16:0] rom [8];
  logic [16:0] rom_q = '0;
  always @(posedge clk) if (bus.mem_en) rom_q <= rom[bus.mem_addr];
  assign bus.mem_data = rom_q;

  typedef struct {
    logic [16:0] frame;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic        imm;
    logic [7:0]  val;
  } vec_t;
  vec_t tbl [8];

  int n_pass = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  // Wait for a frame, check it, optionally hold it off for bp cycles, accept it.
  task automatic accept_frame(input int idx, input int bp, input int exp_cnt);
    int a;
    a = idx % 8;
    wait_valid();
    chk("op", 32'(bus.out_op), 32'(tbl[a].op));
    chk("dst", 32'(bus.out_dst), 32'(tbl[a].dst));
    chk("imm", 32'(bus.out_imm), 32'(tbl[a].imm));
    chk("val", 32'(bus.out_val), 32'(tbl[a].val));
    chk("mem_addr_valid", 32'(bus.mem_addr), 32'(a));
    if (bp > 0) begin
      bus.out_ready = 1'b0;
      repeat (bp) begin
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_op", 32'(bus.out_op), 32'(tbl[a].op));
        chk("bp_dst", 32'(bus.out_dst), 32'(tbl[a].dst));
        chk("bp_val", 32'(bus.out_val), 32'(tbl[a].val));
        chk("bp_pc", 32'(bus.mem_addr), 32'(a));
        chk("bp_cnt", 32'(issue_cnt), 32'(exp_cnt - 1));
      end
      bus.out_ready = 1'b1;
    end
    tick();
    chk("acc_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("acc_cnt", 32'(issue_cnt), 32'(exp_cnt));
    chk("acc_pc", 32'(bus.mem_addr), 32'((a + 1) % 8));
    chk("acc_mem_en", 32'(bus.mem_en), 32'd1);
  endtask

  // Entered in FETCH with pc=6 after six frames were accepted; rom[6]=0.
  task automatic check_after_six();
    tick();  // WAIT
    tick();
`ifdef FETCH_LOOP_EN
    chk("loop_mem_en", 32'(bus.mem_en), 32'd1);
    chk("loop_addr", 32'(bus.mem_addr), 32'd0);
    chk("loop_halted", 32'(halted), 32'd0);
    chk("loop_valid", 32'(bus.out_valid), 32'd0);
    chk("loop_cnt", 32'(issue_cnt), 32'd6);
    accept_frame(0, 0, 7);
`else
    chk("halt_state", 32'(dbg_state), 32'(S_HALT));
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(bus.out_valid), 32'd0);
    chk("halt_cnt", 32'(issue_cnt), 32'd6);
    chk("halt_addr", 32'(bus.mem_addr), 32'd6);
    repeat (3) tick();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_no_valid", 32'(bus.out_valid), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_fields"}, {15'd0, bus.out_op, bus.out_dst, bus.out_imm, bus.out_val}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_cnt"}, 32'(issue_cnt), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{17'b0010_0100_0_0000_0010, 4'h2, 4'h4, 1'b0, 8'h02};
    tbl[1] = '{17'b0010_0100_1_0000_0011, 4'h2, 4'h4, 1'b1, 8'h03};
    tbl[2] = '{17'b0001_0010_0_0101_0101, 4'h1, 4'h2, 1'b0, 8'h55};
    tbl[3] = '{17'b1111_1111_1_1111_1111, 4'hF, 4'hF, 1'b1, 8'hFF};
    tbl[4] = '{17'b0011_0101_0_0111_1100, 4'h3, 4'h5, 1'b0, 8'h7C};
    tbl[5] = '{17'b1000_0001_1_0000_0000, 4'h8, 4'h1, 1'b1, 8'h00};
    tbl[6] = '{17'b0110_0111_1_0001_0001, 4'h6, 4'h7, 1'b1, 8'h11};
    tbl[7] = '{17'b0101_0110_0_1010_1010, 4'h5, 4'h6, 1'b0, 8'hAA};
    for (int i = 0; i < 8; i++) rom[i] = tbl[i].frame;
    rom[6] = 17'b0;
    bus.out_ready = 1'b1;

    // reset
    repeat (2) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_ignores_ready", 32'(dbg_state), 32'(S_IDLE));

    // start latency: mem_en after edge k, out_valid after edge k+2
    pulse_start();
    chk("lat_mem_en", 32'(bus.mem_en), 32'd1);
    chk("lat_addr", 32'(bus.mem_addr), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_valid_k", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_valid_k1", 32'(bus.out_valid), 32'd0);
    chk("lat_mem_en_k1", 32'(bus.mem_en), 32'd0);
    tick();
    chk("lat_valid_k2", 32'(bus.out_valid), 32'd1);

    // frames 0..5 with start-while-busy and backpressure on addr4
    for (int i = 0; i < 6; i++) begin
      accept_frame(i, (i == 4) ? 5 : 0, i + 1);
      if (i == 1) begin
        pulse_start();  // sampled in FETCH: must be ignored
        chk("busy_start_state", 32'(dbg_state), 32'(S_WAIT));
        chk("busy_start_cnt", 32'(issue_cnt), 32'd2);
        chk("busy_start_pc", 32'(bus.mem_addr), 32'd2);
      end
    end
    check_after_six();

    // wrap-around and counter saturation with no terminator
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    tick();
    rst_n = 1'b1;
    rom[6] = tbl[6].frame;
    pulse_start();
    for (int k = 0; k < 260; k++) accept_frame(k, 0, (k + 1 > 255) ? 255 : k + 1);

    // asynchronous reset during WAIT
    tick();
    chk("mid_state", 32'(dbg_state), 32'(S_WAIT));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    chk("mid_no_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_idle", 32'(dbg_state), 32'(S_IDLE));

    // run to terminator again, then restart from HALT
    rom[6] = 17'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) accept_frame(i, 0, i + 1);
    check_after_six();
`ifndef FETCH_LOOP_EN
    pulse_start();
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
    chk("restart_cnt", 32'(issue_cnt), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_mem_en", 32'(bus.mem_en), 32'd1);
    accept_frame(0, 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer that drives the 17-bit instruction ROM and hands each frame downstream.
- Walks the ROM address space, enables the ROM, and captures the registered frame one cycle later.
- Splits the captured frame into fields and presents them on a valid/ready interface to the execute stage.
- Halts on the all-zero terminator frame.

Parameters:
- ADDR_W, 3, ROM address width; matches the `addr` header macro.
- WIDTH, 17, frame width; matches the `width` header macro. The field layout below requires 17.
- CNT_W, 8, width of the issued-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from address 0; honoured only in IDLE or HALT.
- mem_addr  out  ADDR_W  ROM address.
- mem_en  out  1  ROM read enable.
- mem_data  in  WIDTH  ROM registered output (data_frame).
- out_valid  out  1  decoded frame available.
- out_ready  in  1  downstream accepts the frame.
- out_op  out  4  frame[16:13].
- out_dst  out  4  frame[12:9].
- out_imm  out  1  frame[8].
- out_val  out  8  frame[7:0].
- busy  out  1  high in FETCH, WAIT or VALID.
- halted  out  1  high in HALT.
- issue_cnt  out  CNT_W  frames accepted since last start, saturating.

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, mem_addr=0, mem_en=0, out_valid=0, all out_* fields 0, busy=0, halted=0, issue_cnt=0. Reset asserted mid-fetch abandons the in-flight frame with no output.
- States:
  - IDLE: start=1 -> pc=0, issue_cnt=0, go to FETCH.
  - FETCH: mem_en=1, mem_addr=pc for exactly one cycle -> WAIT.
  - WAIT: mem_en=0; mem_data is valid this cycle.
    - mem_data all zeros -> HALT (no out_valid).
    - otherwise -> register the fields and go to VALID.
  - VALID: out_valid=1 and fields held stable until out_ready=1 at a rising edge. On that edge:
    - out_valid drops.
    - issue_cnt increments, saturating at 2^CNT_W-1.
    - pc increments modulo 2^ADDR_W.
    - Go to FETCH.
  - HALT: halted=1. start=1 -> pc=0, issue_cnt=0, go to FETCH, halted drops.
- Latency: start sampled at edge k -> mem_en high after edge k -> out_valid high after edge k+2. Throughput is 1 frame per 3 cycles with out_ready held high.
- The out_valid/out_ready handshake is AXI-style: out_valid never drops without acceptance, and fields are stable while out_valid=1. out_ready in other states is ignored.
- Wrap-around: after the frame at address 2^ADDR_W-1 is accepted, pc wraps to 0 and fetching continues; there is no implicit halt.
- start while busy is ignored.
- mem_addr is registered and always equals pc, including outside FETCH.

Optional Feature:
- FETCH_LOOP_EN
  - Defined: a zero frame in WAIT does not halt. pc resets to 0, the state returns to FETCH, and issue_cnt is preserved (still saturating). halted stays 0 and HALT is unreachable.
  - Undefined: behaviour exactly as above.

Decomposition:
- Shared package (or header):
  - state encoding IDLE/FETCH/WAIT/VALID/HALT as 3-bit localparams
  - field bit positions: OP_MSB=16, OP_LSB=13, DST_MSB=12, DST_LSB=9, IMM_BIT=8, VAL_MSB=7
  - terminator constant 17'b0
- Sub-module: frame_split, a purely combinational field extractor reused by the execute stage. Everything else stays in fetch_seq.

Test Plan:
- Reset/start: bench ROM holds
  - addr0 = 0010_0100_0_0000_0010
  - addr1 = 0010_0100_1_0000_0011
  - addr4 = 0011_0101_0_0111_1100
  - addr6 = 0

  rst_n low then high, start pulse at edge k, out_ready=1 -> out_valid after edge k+2 with op=2, dst=4, imm=0, val=0x02; next frame op=2, dst=4, imm=1, val=0x03; and so on.
- Halt: after 6 frames are accepted, addr6 = 0 -> halted=1, busy=0, out_valid never asserted for it, issue_cnt=6, mem_addr=6.
- Backpressure: out_ready=0 for 5 cycles on the frame at addr4 -> out_valid, op=3, dst=5, val=0x7C held stable throughout; pc unchanged until acceptance.
- Wrap: ROM with no zero frame -> after addr7 is accepted, mem_addr=0 and the frame at addr0 reappears; issue_cnt=9 after the 9th acceptance.
- Reset mid-op: rst_n low during WAIT -> all outputs 0 immediately (async); start in FETCH ignored; restart from HALT gives pc=0 and issue_cnt=0.
- FETCH_LOOP_EN defined: zero frame at addr6 -> next mem_en with mem_addr=0, halted stays 0, issue_cnt continues from 6.
